// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage state encoding, ID/EX payload layout and packing helpers.
package pipe_pkg;

    // Bit 0 = main entry valid, bit 1 = skid entry valid; 2'b10 is illegal.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    // Payload layout, LSB first: imm(32) rd(5) rs2(5) rs1(5) data_b(32) data_a(32).
    localparam int unsigned IMM_W       = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned XLEN        = 32;

    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned RD_LSB      = IMM_LSB + IMM_W;
    localparam int unsigned RS2_LSB     = RD_LSB + REG_W;
    localparam int unsigned RS1_LSB     = RS2_LSB + REG_W;
    localparam int unsigned DATAB_LSB   = RS1_LSB + REG_W;
    localparam int unsigned DATAA_LSB   = DATAB_LSB + XLEN;
    localparam int unsigned IDEX_DATA_W = DATAA_LSB + XLEN;

    // Pack decoded fields into the opaque stage payload.
    function automatic logic [IDEX_DATA_W-1:0] idex_pack(
        input logic [XLEN-1:0]  data_a,
        input logic [XLEN-1:0]  data_b,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic [REG_W-1:0] rd,
        input logic [IMM_W-1:0] imm
    );
        return {data_a, data_b, rs1, rs2, rd, imm};
    endfunction

    // Field extractors for the execute side.
    function automatic logic [XLEN-1:0] idex_data_a(input logic [IDEX_DATA_W-1:0] p);
        return p[DATAA_LSB +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] idex_data_b(input logic [IDEX_DATA_W-1:0] p);
        return p[DATAB_LSB +: XLEN];
    endfunction

    function automatic logic [REG_W-1:0] idex_rd(input logic [IDEX_DATA_W-1:0] p);
        return p[RD_LSB +: REG_W];
    endfunction

    function automatic logic [IMM_W-1:0] idex_imm(input logic [IDEX_DATA_W-1:0] p);
        return p[IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold at the maximum instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/idex_skid_stage.sv
// Elastic ID/EX stage: 2-entry skid buffer with registered in_ready, synchronous flush
// and a saturating bubble counter on the EX side.
module idex_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = IDEX_DATA_W,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready;

    // State register plus the registered handshake/occupancy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Next-state and data-path selection; flush overrides every handshake update.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        state_d     = BUSY;
                    end
                end
                BUSY: begin
                    if (out_fire && in_fire) begin
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path can move.
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        state_d     = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        occupancy_d = 2'd0;
        unique case (state_d)
            EMPTY:   occupancy_d = 2'd0;
            BUSY:    occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // Payload registers: reset-cleared only when data clearing is enabled.
    generate
        if (CLEAR_DATA) begin : g_data_clr
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_data_keep
            always_ff @(posedge clk) begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    endgenerate

    // Bubble monitor: EX was ready but nothing was presented.
    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_ready & ~main_valid),
        .count (bubble_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

    // A skid entry without a main entry would break FIFO order.
    assert property (@(posedge clk) disable iff (reset) !(skid_valid && !main_valid))
        else $error("idex_skid_stage: skid entry held without main entry");

    // in_ready is a plain flop and must mirror the skid slot being free.
    assert property (@(posedge clk) disable iff (reset) in_ready_q == !skid_valid)
        else $error("idex_skid_stage: in_ready out of step with skid state");

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_idex_skid_stage;
    import pipe_pkg::*;

    localparam int unsigned DW = IDEX_DATA_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   bubble_cnt;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [2:0]    s_bubble_cnt;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    idex_skid_stage #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    // Same stimulus, narrow counter to exercise saturation.
    idex_skid_stage #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two payloads plus bubble tallies.
    logic [DW-1:0] mq[$];
    int unsigned   bub16 = 0;
    int unsigned   bub3  = 0;
    bit            m_in_fire, m_out_fire;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            bub16 = 0;
            bub3  = 0;
        end else begin
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = out_ready && (mq.size() > 0);
            if (out_ready && mq.size() == 0) begin
                if (bub16 < 65535) bub16++;
                if (bub3 < 7) bub3++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(in_data);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", out_valid, mq.size() > 0);
            check("in_ready", in_ready, mq.size() < 2);
            check("occupancy", occupancy, mq.size());
            check("bubble_cnt", bubble_cnt, bub16);
            check("bubble_cnt_w3", s_bubble_cnt, bub3);
            check("sat_out_valid", s_out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("out_data", out_data, mq[0]);
                check("sat_out_data", s_out_data, mq[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] rnd;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #2;
        checking = 1'b1;
        tick();
        // Reset state.
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_out_data", out_data, 0);

        // Streaming at full rate: one-cycle latency, occupancy steady at 1.
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(1);
        tick();
        check("stream1_data", out_data, 1);
        check("stream1_occ", occupancy, 1);
        check("stream1_rdy", in_ready, 1);
        in_data = DW'(2);
        tick();
        check("stream2_data", out_data, 2);
        check("stream2_occ", occupancy, 1);
        in_data = DW'(3);
        tick();
        check("stream3_data", out_data, 3);
        check("stream3_rdy", in_ready, 1);
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);

        // Backpressure fills the skid slot, then drains in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('hA);
        tick();
        in_data = DW'('hB);
        tick();
        in_valid = 1'b0;
        check("bp_occ", occupancy, 2);
        check("bp_rdy", in_ready, 0);
        check("bp_hold", out_data, 'hA);
        tick();
        check("bp_stable", out_data, 'hA);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_data, 'hB);
        check("bp_rdy_back", in_ready, 1);
        check("bp_occ1", occupancy, 1);
        tick();
        check("bp_empty", out_valid, 0);

        // Flush while FULL, with a competing input that must never surface.
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('hA);
        tick();
        in_data = DW'('hB);
        tick();
        flush = 1'b1; in_data = DW'('hC);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_occ", occupancy, 0);
        check("fl_data", out_data, 0);
        check("fl_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_c", out_valid, 0);
        end

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('h55);
        tick();
        in_data = DW'('h66);
        tick();
        in_valid = 1'b0;
        check("ar_pre_occ", occupancy, 2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_rdy", in_ready, 1);
        check("ar_occ", occupancy, 0);
        check("ar_data", out_data, 0);
        tick();
        reset = 1'b0;

        // Idle with EX ready: bubble counter counts, narrow copy saturates.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("bub5", bubble_cnt, 5);
        check("bub5_w3", s_bubble_cnt, 5);
        for (int i = 0; i < 5; i++) tick();
        check("bub10", bubble_cnt, 10);
        check("bub10_w3", s_bubble_cnt, 7);
        // Flush does not clear the counter.
        flush = 1'b1;
        out_ready = 1'b0;
        tick();
        flush = 1'b0;
        check("bub_keep", bubble_cnt, 10);

        // Random traffic scored against the model every cycle.
        for (int i = 0; i < 10000; i++) begin
            rnd       = {$urandom, $urandom, $urandom, $urandom};
            in_data   = rnd[DW-1:0];
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
